// File: rtl/ram16k_pkg.sv
// Shared types and constants for the RAM16K access arbiter.
package ram16k_pkg;

    localparam int RAM16K_ADDR_W = 14;
    localparam int RAM16K_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // A new request can only be taken while the RAM port is not being driven.
    function automatic logic can_accept(state_t s);
        return (s == IDLE) || (s == RESP);
    endfunction

endpackage

// File: rtl/ram16k_arbiter_rr_arb2.sv
// Two-requester arbiter for the RAM16K port.
// Default: round-robin on last_grant. With RAM16K_ARB_FIXED_PRIO_EN defined,
// port A wins every tie and the last_grant input does not exist.
module rr_arb2
    import ram16k_pkg::*;
(
    input  logic [1:0] valid_i,       // {B, A}
`ifndef RAM16K_ARB_FIXED_PRIO_EN
    input  port_id_t   last_grant_i,
`endif
    input  logic       enable_i,
    output logic [1:0] grant_o        // one-hot {B, A}, zero when nothing wins
);

    // Pick at most one valid requester; nothing is granted while disabled.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
`ifdef RAM16K_ARB_FIXED_PRIO_EN
                2'b11:   grant_o = 2'b01;
`else
                2'b11:   grant_o = (last_grant_i == PORT_A) ? 2'b10 : 2'b01;
`endif
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter / access sequencer for the single RAM16K word port.
// Each accepted request takes one ACCESS cycle on the RAM and answers with a
// one-cycle response pulse in the following RESP cycle; RESP may also accept
// the next request, giving one access every two cycles.
// Optional macro RAM16K_ARB_FIXED_PRIO_EN: fixed A-over-B priority instead
// of round-robin (no last_grant register is built).
module ram16k_arbiter
    import ram16k_pkg::*;
#(
    parameter int ADDR_W = RAM16K_ADDR_W,
    parameter int DATA_W = RAM16K_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              busy
);

    state_t              state_q, state_d;
    port_id_t            port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifndef RAM16K_ARB_FIXED_PRIO_EN
    port_id_t            last_grant_q, last_grant_d;
`endif

    logic       accept_win;
    logic [1:0] grant;
    logic       accept;

    // Reset overrides the accept window so ready is never seen during reset.
    assign accept_win = can_accept(state_q) & ~rst;

    rr_arb2 u_arb (
        .valid_i      ({b_req_valid, a_req_valid}),
`ifndef RAM16K_ARB_FIXED_PRIO_EN
        .last_grant_i (last_grant_q),
`endif
        .enable_i     (accept_win),
        .grant_o      (grant)
    );

    assign accept = |grant;

    // Next-state, request latching and all block outputs.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
`ifndef RAM16K_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        a_req_ready = grant[0];
        b_req_ready = grant[1];
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        a_rsp_rdata = rdata_q;
        b_rsp_rdata = rdata_q;
        // Address and data sit on the latched request, so they hold their
        // last values whenever the RAM is not being accessed.
        ram_addr    = addr_q;
        ram_din     = wdata_q;
        ram_load    = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = accept ? ACCESS : IDLE;
            end
            ACCESS: begin
                busy     = 1'b1;
                // A reset arriving mid-access must not corrupt the RAM.
                ram_load = we_q & ~rst;
                rdata_d  = ram_dout;
                state_d  = RESP;
            end
            RESP: begin
                a_rsp_valid = (port_q == PORT_A) & ~rst;
                b_rsp_valid = (port_q == PORT_B) & ~rst;
                state_d     = accept ? ACCESS : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            port_d  = grant[1] ? PORT_B : PORT_A;
            we_d    = grant[1] ? b_req_we    : a_req_we;
            addr_d  = grant[1] ? b_req_addr  : a_req_addr;
            wdata_d = grant[1] ? b_req_wdata : a_req_wdata;
`ifndef RAM16K_ARB_FIXED_PRIO_EN
            last_grant_d = grant[1] ? PORT_B : PORT_A;
`endif
        end
    end

    // State and latched-request registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= PORT_A;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
`ifndef RAM16K_ARB_FIXED_PRIO_EN
            last_grant_q <= PORT_B;
`endif
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
`ifndef RAM16K_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: cycle table for the directed scenarios, a random
// two-requester run checked against a transaction-level model, and a short
// arbitration sequence after reset. The bench owns the RAM contents.
module tb_ram16k_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [13:0] a_req_addr = '0;
    logic [15:0] a_req_wdata = '0;
    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [13:0] b_req_addr = '0;
    logic [15:0] b_req_wdata = '0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [15:0] a_rsp_rdata, b_rsp_rdata;
    logic [13:0] ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        ram_load, busy;

    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    logic        wr_pend = 1'b0;
    logic [13:0] wr_a = '0;
    logic [15:0] wr_d = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    ram16k_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_load(ram_load),
        .ram_dout(ram_dout), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample outputs mid-cycle; remember any RAM write to apply at the edge.
    task automatic sample();
        @(negedge clk);
        wr_pend = ram_load;
        wr_a    = ram_addr;
        wr_d    = ram_din;
    endtask

    task automatic step();
        @(posedge clk);
        if (wr_pend) mem[wr_a] = wr_d;
        wr_pend = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            step();
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 16384; i++) begin
            logic [15:0] v;
            v = 16'((i * 37) ^ 16'h5A00);
            mem[i]     = v;
            ref_mem[i] = v;
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        rst;
        logic        av, awe;
        logic [13:0] aa;
        logic [15:0] ad;
        logic        bv, bwe;
        logic [13:0] ba;
        logic [15:0] bd;
        logic [5:0]  ex;    // {a_ready, b_ready, a_rsp, b_rsp, ram_load, busy}
        int          ck;    // 0 none, 1 a_rdata, 2 b_rdata, 3 ram_addr
        logic [15:0] ev;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic av, input logic awe, input logic [13:0] aa,
                       input logic [15:0] ad, input logic bv, input logic bwe,
                       input logic [13:0] ba, input logic [15:0] bd, input logic [5:0] ex,
                       input int ck, input logic [15:0] ev);
        vec_t v;
        v.rst = r; v.av = av; v.awe = awe; v.aa = aa; v.ad = ad;
        v.bv = bv; v.bwe = bwe; v.ba = ba; v.bd = bd; v.ex = ex; v.ck = ck; v.ev = ev;
        vecs.push_back(v);
    endtask

    task automatic build_table();
        // reset holds ready low even with a request present
        add(1, 1,1,14'h0123,16'hBEEF, 0,0,0,0, 6'b000000, 0, 0);
        // A write 0x0123 = 0xBEEF
        add(0, 1,1,14'h0123,16'hBEEF, 0,0,0,0, 6'b100000, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000011, 3, 16'h0123);
        add(0, 0,0,0,0,               0,0,0,0, 6'b001000, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000000, 0, 0);
        // A read back 0x0123
        add(0, 1,0,14'h0123,0,        0,0,0,0, 6'b100000, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000001, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b001000, 1, 16'hBEEF);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000000, 0, 0);
`ifndef RAM16K_ARB_FIXED_PRIO_EN
        // contention, last winner A: B, A, B, A
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b010000, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b000001, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b100100, 2, 16'hCFFF);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b000001, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b011000, 1, 16'hC001);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b000001, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b100100, 2, 16'hCFFF);
        add(0, 0,0,0,0,        0,0,0,0,        6'b000001, 0, 0);
        add(0, 0,0,0,0,        0,0,0,0,        6'b001000, 1, 16'hC001);
        add(0, 0,0,0,0,        0,0,0,0,        6'b000000, 0, 0);
`else
        // contention under fixed priority: A every time
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b100000, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b000001, 0, 0);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b101000, 1, 16'hC001);
        add(0, 1,0,14'h0001,0, 1,0,14'h3FFF,0, 6'b000001, 0, 0);
        add(0, 0,0,0,0,        0,0,0,0,        6'b001000, 1, 16'hC001);
        add(0, 0,0,0,0,        0,0,0,0,        6'b000000, 0, 0);
`endif
        // B write 0x3FFF = 0x5A5A, A read 0x3FFF accepted in B's RESP
        add(0, 0,0,0,0,        1,1,14'h3FFF,16'h5A5A, 6'b010000, 0, 0);
        add(0, 0,0,0,0,        0,0,0,0,               6'b000011, 3, 16'h3FFF);
        add(0, 1,0,14'h3FFF,0, 0,0,0,0,               6'b100100, 0, 0);
        add(0, 0,0,0,0,        0,0,0,0,               6'b000001, 0, 0);
        add(0, 0,0,0,0,        0,0,0,0,               6'b001000, 1, 16'h5A5A);
        add(0, 0,0,0,0,        0,0,0,0,               6'b000000, 0, 0);
        // reset during the ACCESS of A write 0x0010 = 0x1111
        add(0, 1,1,14'h0010,16'h1111, 0,0,0,0, 6'b100000, 0, 0);
        add(1, 0,0,0,0,               0,0,0,0, 6'b000001, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000000, 0, 0);
        add(0, 1,0,14'h0010,0,        0,0,0,0, 6'b100000, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000001, 0, 0);
        add(0, 0,0,0,0,               0,0,0,0, 6'b001000, 1, 16'h2222);
        add(0, 0,0,0,0,               0,0,0,0, 6'b000000, 0, 0);
    endtask

    // ---------------- random run with transaction model ----------------
    typedef struct {
        int          port;
        logic        we;
        logic [15:0] rd;
        int          due;
    } rsp_t;

    rsp_t        pq[$];
    logic [1:0]  rq_v;
    logic [1:0]  rq_we;
    logic [13:0] rq_a [2];
    logic [15:0] rq_d [2];

    function automatic logic [13:0] pick_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 8) return 14'(k);
        if (k == 8) return 14'h3FFF;
        return 14'($urandom);
    endfunction

    task automatic new_req(input int p);
        rq_v[p]  = 1'b1;
        rq_we[p] = 1'($urandom_range(0, 1));
        rq_a[p]  = pick_addr();
        rq_d[p]  = 16'($urandom);
    endtask

    task automatic random_run(input int ncyc);
        int          last;      // 0 = A, 1 = B
        logic        prev_acc;
        logic        exp_load;
        logic [1:0]  eg, er;
        rsp_t        e;
        logic        have;
        last = 1; prev_acc = 1'b0; exp_load = 1'b0;
        rq_v = 2'b00; rq_we = 2'b00;
        pq.delete();
        for (int c = 0; c < ncyc + 6; c++) begin
            a_req_valid = rq_v[0]; a_req_we = rq_we[0]; a_req_addr = rq_a[0]; a_req_wdata = rq_d[0];
            b_req_valid = rq_v[1]; b_req_we = rq_we[1]; b_req_addr = rq_a[1]; b_req_wdata = rq_d[1];
            sample();
            // at most one acceptance per two cycles; ties go by the arbitration rule
            eg = 2'b00;
            if (!prev_acc) begin
`ifdef RAM16K_ARB_FIXED_PRIO_EN
                if (rq_v[0]) eg = 2'b01;
                else if (rq_v[1]) eg = 2'b10;
`else
                if (rq_v == 2'b11) eg = (last == 0) ? 2'b10 : 2'b01;
                else eg = rq_v;
`endif
            end
            chk("rand_ready", {b_req_ready, a_req_ready}, eg);
            chk("rand_load", ram_load, exp_load);
            er = 2'b00; have = 1'b0;
            if (pq.size() > 0 && pq[0].due == c) begin
                e = pq.pop_front();
                have = 1'b1;
                er[e.port] = 1'b1;
            end
            chk("rand_rsp_valid", {b_rsp_valid, a_rsp_valid}, er);
            if (have && !e.we)
                chk("rand_rdata", (e.port == 1) ? b_rsp_rdata : a_rsp_rdata, e.rd);
            exp_load = 1'b0;
            if (eg != 2'b00) begin
                rsp_t n;
                n.port = eg[1] ? 1 : 0;
                n.we   = rq_we[n.port];
                n.rd   = ref_mem[rq_a[n.port]];
                n.due  = c + 2;
                if (n.we) ref_mem[rq_a[n.port]] = rq_d[n.port];
                exp_load = n.we;
                pq.push_back(n);
                last = n.port;
                rq_v[n.port] = 1'b0;
            end
            prev_acc = (eg != 2'b00);
            step();
            for (int p = 0; p < 2; p++) begin
                if (c >= ncyc) rq_v[p] = 1'b0;
                else if (rq_v[p]) begin
                    if ($urandom_range(0, 7) == 0) rq_v[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) new_req(p);
            end
        end
        chk("rand_drained", pq.size(), 0);
    endtask

    initial begin
        init_mem();
        mem[14'h0001] = 16'hC001;
        mem[14'h3FFF] = 16'hCFFF;
        mem[14'h0010] = 16'h2222;
        mem[14'h0123] = 16'h0000;
        rst = 1'b1;
        idle(3);

        build_table();
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            a_req_valid = vecs[i].av; a_req_we = vecs[i].awe;
            a_req_addr = vecs[i].aa;  a_req_wdata = vecs[i].ad;
            b_req_valid = vecs[i].bv; b_req_we = vecs[i].bwe;
            b_req_addr = vecs[i].ba;  b_req_wdata = vecs[i].bd;
            sample();
            chk($sformatf("vec%0d_flags", i),
                {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_load, busy}, vecs[i].ex);
            case (vecs[i].ck)
                1: chk($sformatf("vec%0d_a_rdata", i), a_rsp_rdata, vecs[i].ev);
                2: chk($sformatf("vec%0d_b_rdata", i), b_rsp_rdata, vecs[i].ev);
                3: chk($sformatf("vec%0d_ram_addr", i), ram_addr, 32'(vecs[i].ev[13:0]));
                default: ;
            endcase
            step();
        end

        // random traffic from a clean reset
        rst = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        init_mem();
        idle(2);
        rst = 1'b0;
        random_run(2000);

        // after reset, A wins the first tie
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 14'h0001;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 14'h3FFF;
`ifdef RAM16K_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) begin
            sample();
            chk($sformatf("fp_a_ready%0d", i), a_req_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("fp_b_ready%0d", i), b_req_ready, 0);
            step();
        end
        a_req_valid = 1'b0;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                sample();
                got = b_req_ready;
                step();
                if (got) b_req_valid = 1'b0;
            end
            chk("fp_b_granted", got, 1);
        end
`else
        sample();
        chk("tie_a_first", {a_req_ready, b_req_ready}, 2'b10);
        step();
        sample();
        chk("tie_access", {a_req_ready, b_req_ready, busy}, 3'b001);
        step();
        sample();
        chk("tie_b_next", {a_req_ready, b_req_ready, a_rsp_valid}, 3'b011);
        step();
`endif
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
